// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised stall/flush sequencer for the 5-stage pipeline (optional perf counters via PERF_COUNT_EN)
module pipe_hazard_ctrl #(
  parameter logic [31:0] NOHALT_CODE = 32'h22,
  parameter int          MDU_LAT     = 4,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             jmp_ex,
  input  logic             syscall_ex,
  input  logic [31:0]      syscall_code,
  input  logic             mdu_start,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_jmp,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_stall
);
  localparam logic [1:0] RUN = 2'd0, MDU_WAIT = 2'd1, HALT = 2'd2, RESUME = 2'd3;
  localparam int MW = $clog2(MDU_LAT + 1);
  localparam logic LONG_MDU = MDU_LAT > 2;
  if (MDU_LAT < 2) begin : g_bad_lat
    $error("MDU_LAT must be >= 2");
  end
  logic [1:0] state, state_nx;
  logic [MW-1:0] mdu_cnt, mdu_cnt_nx;
  logic go_q, go_rise, halt_req, mdu_stall, freeze, redirect, lu_stall;
  always_comb begin
    go_rise   = go & ~go_q;
    halt_req  = (state == RUN) & syscall_ex & (syscall_code != NOHALT_CODE);
    mdu_stall = (state == MDU_WAIT) | ((state == RUN) & mdu_start & ~halt_req);
    freeze    = (state == HALT) | halt_req | mdu_stall;
    redirect  = ~freeze & (branch_taken | jmp_ex);
    lu_stall  = ~freeze & ~redirect & load_use;
    pc_en        = ~rst & ~freeze & ~lu_stall;
    if_id_en     = ~rst & ~freeze & ~lu_stall;
    id_ex_en     = ~rst & ~freeze;
    if_id_flush  = rst | redirect;
    id_ex_flush  = rst | redirect | lu_stall;
    ex_mem_flush = rst | freeze;
    halted       = ~rst & (state == HALT);
    // the mdu_start cycle is itself a stall, so MDU_WAIT covers the remaining MDU_LAT-2 cycles
    state_nx = (state == RUN)      ? (halt_req ? HALT : (mdu_start & LONG_MDU) ? MDU_WAIT : RUN) :
               (state == MDU_WAIT) ? ((mdu_cnt <= MW'(1)) ? RUN : MDU_WAIT) :
               (state == HALT)     ? (go_rise ? RESUME : HALT) : RUN;
    mdu_cnt_nx = ((state == RUN) & ~halt_req & mdu_start) ? MW'(MDU_LAT - 2) :
                 ((state == MDU_WAIT) & (mdu_cnt > MW'(1))) ? mdu_cnt - MW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      mdu_cnt <= '0;
      go_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      mdu_cnt <= mdu_cnt_nx;
      go_q    <= go;
    end
  end
`ifdef PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_cycle    <= '0;
      cnt_branch   <= '0;
      cnt_jmp      <= '0;
      cnt_load_use <= '0;
      cnt_stall    <= '0;
    end else begin
      cnt_cycle    <= cnt_cycle + CNT_W'(state != HALT);
      cnt_branch   <= cnt_branch + CNT_W'(redirect & branch_taken);
      cnt_jmp      <= cnt_jmp + CNT_W'(redirect & jmp_ex);
      cnt_load_use <= cnt_load_use + CNT_W'(lu_stall);
      cnt_stall    <= cnt_stall + CNT_W'(mdu_stall);
    end
  end
`else
  assign cnt_cycle    = '0;
  assign cnt_branch   = '0;
  assign cnt_jmp      = '0;
  assign cnt_load_use = '0;
  assign cnt_stall    = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + randomized check of pipe_hazard_ctrl against a flag/countdown reference model
module tb_pipe_hazard_ctrl;
  localparam int MDU_LAT = 4;
  localparam logic [31:0] NOHALT = 32'h22;
`ifdef PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1, go = 1'b0, load_use = 1'b0, branch_taken = 1'b0, jmp_ex = 1'b0;
  logic syscall_ex = 1'b0, mdu_start = 1'b0;
  logic [31:0] syscall_code = '0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, halted;
  logic [31:0] cnt_cycle, cnt_branch, cnt_jmp, cnt_load_use, cnt_stall;
  int checks = 0, errors = 0;
  bit m_halt = 0, m_resume = 0, m_goq = 0;
  int m_stall = 0;
  logic [31:0] e_cyc = '0, e_br = '0, e_jmp = '0, e_lu = '0, e_st = '0;
  pipe_hazard_ctrl #(.NOHALT_CODE(NOHALT), .MDU_LAT(MDU_LAT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .go(go), .load_use(load_use), .branch_taken(branch_taken),
    .jmp_ex(jmp_ex), .syscall_ex(syscall_ex), .syscall_code(syscall_code), .mdu_start(mdu_start),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .halted(halted),
    .cnt_cycle(cnt_cycle), .cnt_branch(cnt_branch), .cnt_jmp(cnt_jmp),
    .cnt_load_use(cnt_load_use), .cnt_stall(cnt_stall));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // ctl vector order: pc_en if_id_en id_ex_en if_id_flush id_ex_flush ex_mem_flush halted
  task automatic step(input bit r, input bit g, input bit lu, input bit br, input bit jm,
                      input bit sc, input logic [31:0] code, input bit ms);
    bit run, hreq, stl, frz, rd, lus;
    logic [6:0] exp;
    rst = r; go = g; load_use = lu; branch_taken = br; jmp_ex = jm;
    syscall_ex = sc; syscall_code = code; mdu_start = ms;
    #1;
    run  = !m_halt && !m_resume && m_stall == 0;
    hreq = run && sc && code != NOHALT;
    stl  = m_stall > 0 || (run && !hreq && ms);
    frz  = m_halt || hreq || stl;
    rd   = !frz && (br || jm);
    lus  = !frz && !rd && lu;
    exp  = r ? 7'b0001110 : {!frz && !lus, !frz && !lus, !frz, rd, rd || lus, frz, m_halt};
    check("ctl", {25'd0, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, halted},
          {25'd0, exp});
    check("cnt_cycle", cnt_cycle, PERF ? e_cyc : 32'd0);
    check("cnt_branch", cnt_branch, PERF ? e_br : 32'd0);
    check("cnt_jmp", cnt_jmp, PERF ? e_jmp : 32'd0);
    check("cnt_load_use", cnt_load_use, PERF ? e_lu : 32'd0);
    check("cnt_stall", cnt_stall, PERF ? e_st : 32'd0);
    @(posedge clk);
    if (r) begin
      m_halt = 0; m_resume = 0; m_goq = 0; m_stall = 0;
      e_cyc = '0; e_br = '0; e_jmp = '0; e_lu = '0; e_st = '0;
    end else begin
      e_cyc += 32'(!m_halt);
      e_br  += 32'(rd && br);
      e_jmp += 32'(rd && jm);
      e_lu  += 32'(lus);
      e_st  += 32'(stl);
      if (m_halt) begin
        if (g && !m_goq) begin m_halt = 0; m_resume = 1; end
      end else if (m_resume) m_resume = 0;
      else if (m_stall > 0) m_stall--;
      else if (hreq) m_halt = 1;
      else if (ms) m_stall = MDU_LAT - 2;
      m_goq = g;
    end
    @(negedge clk);
  endtask
  initial begin
    bit g;
    @(negedge clk);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0A, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'h0A, 0);
    step(0, 1, 1, 0, 1, 1, 32'h0A, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, NOHALT, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    repeat (4) step(0, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'h0A, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'h0A, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    g = 0;
    repeat (4000) begin
      if ($urandom_range(5) == 0) g = ~g;
      step($urandom_range(99) == 0, g, $urandom_range(3) == 0, $urandom_range(5) == 0,
           $urandom_range(7) == 0, $urandom_range(7) == 0,
           $urandom_range(1) ? NOHALT : $urandom, $urandom_range(5) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
